// File: rtl/mult4bit_seq.sv
// Purpose: unsigned N x N sequential shift-and-add multiplier producing a 2N-bit product.
// Latency: N+1 clocks from the accepted start to the done strobe; one result every N+1 cycles back-to-back.
// Backpressure: none; start is accepted only in IDLE or DONE and is ignored while busy.
module mult4bit_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   inA,
  input  logic [N-1:0]   inB,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         stateNext;
  logic [N-1:0]   mcand;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] accNext;
  logic [CW-1:0]  cnt;
  logic [N:0]     sum;
  logic           accept;
  logic           lastIter;

  // Operand acceptance, last-iteration detect and next state.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    lastIter  = 1'b0;
    unique case (state)
      IDLE: begin
        accept = start;
        if (start) stateNext = RUN;
      end
      RUN: begin
        lastIter = (cnt == CW'(N - 1));
        if (lastIter) stateNext = DONE;
      end
      DONE: begin
        accept    = start;
        stateNext = start ? RUN : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // One partial-product step: conditional add of the multiplicand into the
  // upper half, then shift right with the adder carry landing in the MSB.
  always_comb begin
    sum = {1'b0, acc[2*N-1:N]};
    if (acc[0]) sum = {1'b0, acc[2*N-1:N]} + {1'b0, mcand};
    accNext = {sum, acc[N-1:1]};
  end

  // State register plus registered status outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= stateNext;
      busy  <= (stateNext == RUN);
      done  <= (stateNext == DONE);
    end
  end

  // Datapath: operand capture on accept, one iteration per RUN cycle, and a
  // product update only on the final iteration so p never shows partial sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
    end else if (accept) begin
      mcand <= inA;
      acc   <= {{N{1'b0}}, inB};
      cnt   <= '0;
    end else if (state == RUN) begin
      acc <= accNext;
      cnt <= cnt + 1'b1;
      if (lastIter) p <= accNext;
    end
  end

endmodule

// File: tb/tb_mult4bit_seq.sv
// Directed bench for mult4bit_seq: reset, corners, ignored restart, abort, back-to-back, exhaustive.
// Outputs are sampled 1ns after the rising edge; inputs change at the same point.
// Each comparison is an immediate assertion; the summary line reports totals.
module tb_mult4bit_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] inA;
  logic [3:0] inB;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int tests;
  int failures;
  int pulses;

  mult4bit_seq #(.N(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .inA   (inA),
    .inB   (inB),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one cycle; returns in cycle 1 (first RUN).
  task automatic startOp(input int a, input int b);
    start = 1'b1;
    inA   = 4'(a);
    inB   = 4'(b);
    tick();
    start = 1'b0;
  endtask

  // Full directed operation with cycle-by-cycle status checks.
  task automatic fullOp(input string tag, input int a, input int b, input logic [7:0] exp);
    logic [7:0] pBefore;
    pBefore = p;
    startOp(a, b);
    for (int i = 1; i <= 4; i++) begin
      chk({tag, "_busy"}, 16'(busy), 16'd1);
      chk({tag, "_nodone"}, 16'(done), 16'd0);
      chk({tag, "_phold"}, 16'(p), 16'(pBefore));
      tick();
    end
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_busy_low"}, 16'(busy), 16'd0);
    chk({tag, "_p"}, 16'(p), 16'(exp));
    tick();
    chk({tag, "_done_drop"}, 16'(done), 16'd0);
    chk({tag, "_idle"}, 16'(busy), 16'd0);
    chk({tag, "_p_held"}, 16'(p), 16'(exp));
  endtask

  initial begin
    int cyc;
    tests    = 0;
    failures = 0;
    pulses   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    inA      = 4'd0;
    inB      = 4'd0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_p", 16'(p), 16'd0);
    rst = 1'b0;

    // Basic and corner operands, first start right after reset release
    fullOp("basic_3x5", 3, 5, 8'h0F);
    fullOp("c_0x0", 0, 0, 8'h00);
    fullOp("c_15x15", 15, 15, 8'hE1);
    fullOp("c_15x1", 15, 1, 8'h0F);
    fullOp("c_1x15", 1, 15, 8'h0F);

    // Start pulsed during RUN with new operands is ignored
    startOp(9, 7);
    start = 1'b1;
    inA   = 4'd2;
    inB   = 4'd2;
    tick();
    start = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      chk("ign_busy", 16'(busy), 16'd1);
      chk("ign_nodone", 16'(done), 16'd0);
      tick();
    end
    chk("ign_done", 16'(done), 16'd1);
    chk("ign_p", 16'(p), 16'h3F);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("ign_single_done", 16'(pulses), 16'd0);
    chk("ign_idle", 16'(busy), 16'd0);

    // Reset asserted in the second RUN cycle aborts the operation
    startOp(12, 11);
    tick();
    chk("abort_running", 16'(busy), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_p", 16'(p), 16'd0);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("abort_no_done", 16'(pulses), 16'd0);
    fullOp("after_abort_2x3", 2, 3, 8'h06);

    // Back-to-back with start held high
    start = 1'b1;
    inA   = 4'd4;
    inB   = 4'd4;
    for (int i = 1; i <= 5; i++) tick();
    chk("b2b_done1", 16'(done), 16'd1);
    chk("b2b_p1", 16'(p), 16'h10);
    inA = 4'd5;
    inB = 4'd6;
    tick();
    chk("b2b_busy6", 16'(busy), 16'd1);
    chk("b2b_nodone6", 16'(done), 16'd0);
    for (int i = 7; i <= 10; i++) tick();
    chk("b2b_done10", 16'(done), 16'd1);
    chk("b2b_p2", 16'(p), 16'h1E);
    start = 1'b0;
    tick();
    chk("b2b_idle", 16'(busy), 16'd0);
    chk("b2b_p_held", 16'(p), 16'h1E);

    // Exhaustive: every operand pair, product and latency checked at done
    pulses = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        startOp(a, b);
        cyc = 1;
        while (!done && cyc < 9) begin
          tick();
          cyc++;
        end
        if (done) pulses++;
        chk("exh_lat", 16'(cyc), 16'd5);
        chk("exh_p", 16'(p), 16'(a * b));
      end
    end
    tick();
    chk("exh_pulses", 16'(pulses), 16'd256);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mult4bit_seq.md
# mult4bit_seq

Sequential shift-and-add multiplier that consumes 4-bit additions of the kind `adder4bit` produces. It iterates one partial-product add per clock to form an 8-bit product from two 4-bit operands. It sits directly downstream of the 4-bit adder datapath in the arithmetic chain. Operands are latched on a start pulse, and the block reports completion with a one-cycle done strobe.

## Interface
- `N`, default 4: operand width. The product is 2N bits wide. The iteration counter is clog2(N+1) bits wide.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `inA`  in  N  multiplicand; sampled when start is accepted.
- `inB`  in  N  multiplier; sampled when start is accepted.
- `busy`  out  1  high while an operation is in progress (RUN).
- `done`  out  1  one-cycle strobe; p is valid and new.
- `p`  out  2N  product register; holds its value until the next completion.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - When start=1, latch `mcand<=inA`, load `acc<={N'b0, inB}`, set `cnt<=0`, and go to RUN.
  - When start=0, stay in IDLE.
- RUN, one iteration per cycle:
  - If acc[0]=1, form `sum = {1'b0, acc[2N-1:N]} + {1'b0, mcand}`, which is N+1 bits.
  - Otherwise, `sum = {1'b0, acc[2N-1:N]}`.
  - Update `acc <= {sum, acc[N-1:1]}`, i.e. a right shift with the carry-out entering the MSB.
  - Increment cnt.
  - When cnt reaches N-1 in a RUN cycle, that cycle is the last iteration. At that edge, load p with the final acc value and go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - When start=1, accept new operands (same actions as IDLE) and go to RUN; this allows back-to-back operation.
  - When start=0, go to IDLE.
- start is ignored in RUN:
  - No restart occurs.
  - Operands are not resampled.
  - The inA/inB change has no effect on the in-flight product.
- Arithmetic is unsigned only. The product never overflows 2N bits, because (2^N-1)^2 < 2^2N. The carry of the N+1-bit add is never lost.
- p is written only on the RUN→DONE transition. p is never exposed mid-computation.
- Reset at any time, including mid-RUN:
  - Next state is IDLE.
  - busy=0, done=0, p=0, acc=0, mcand=0, cnt=0.
  - The in-flight result is discarded.
- Reset has priority over start in the same cycle.

## Timing
- Cycle 0: start=1 while in IDLE or DONE; it is accepted at the edge ending cycle 0.
- Cycles 1..N: state RUN, busy=1, done=0.
- Cycle N+1: state DONE, busy=0, done=1, p equals inA*inB.
- Latency from the start cycle to the done cycle is N+1 clocks, i.e. 5 for N=4.
- With start held high continuously, throughput is one result every N+1 cycles.
- Outputs are registered and have no combinational input-to-output path.
- Reset values: busy=0, done=0, p=0.
- The first accepted start may occur in the cycle immediately after rst deasserts.

## Test plan
- Basic: rst 2 cycles, then start with inA=3, inB=5. Required: busy=1 for 4 cycles, then done=1 for one cycle with p=8'h0F, then IDLE with p held at 8'h0F.
- Corner values:
  - 0×0 gives p=8'h00 and done still pulses after 5 cycles.
  - 15×15 gives p=8'hE1.
  - 15×1 gives p=8'h0F.
  - 1×15 gives p=8'h0F.
- Ignored restart: start 9×7. During RUN, pulse start with inA=2, inB=2. Required: only one done, with p=8'h3F (63), and busy never drops early.
- Reset mid-op: start 12×11, then assert rst in the 2nd RUN cycle. Required: next cycle busy=0, done=0, p=0. No done appears for the aborted operation. A following 2×3 gives p=8'h06.
- Back-to-back: hold start high with 4×4, then present 5×6 in the DONE cycle. Required:
  - done in cycle 5 with p=8'h10.
  - busy high again in cycle 6.
  - done in cycle 10 with p=8'h1E.
- Exhaustive: all 256 (inA, inB) pairs, each checked at done against inA*inB. Required: zero mismatches and exactly 256 done pulses.
